issue_ctrl: RTL and testbench

//  Issue controller between the decode stage and the execution units (ALU/BJU/AGU/CSU).

---
 rtl/issue_ctrl_pkg.sv | 37 +++
 rtl/issue_ctrl_sb_bits.sv | 52 +++++
 rtl/issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_issue_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the issue controller: FSM states, trap causes,
// unit-select layout and the trap-cause encoder.
package issue_ctrl_pkg;

    localparam int USELE_W  = 4;
    localparam int SELE_ALU = 0;
    localparam int SELE_BJU = 1;
    localparam int SELE_AGU = 2;
    localparam int SELE_CSU = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2,
        ST_HALT  = 2'd3
    } issue_st_e;

    typedef enum logic [1:0] {
        TRAP_NONE   = 2'b00,
        TRAP_ILGL   = 2'b01,
        TRAP_ECALL  = 2'b10,
        TRAP_EBREAK = 2'b11
    } trap_cause_e;

    // Illegal outranks ecall, which outranks ebreak.
    function automatic trap_cause_e trap_cause(input logic ilgl, input logic [1:0] ecallbreak);
        if (ilgl)
            return TRAP_ILGL;
        else if (ecallbreak[1])
            return TRAP_ECALL;
        else if (ecallbreak[0])
            return TRAP_EBREAK;
        else
            return TRAP_NONE;
    endfunction

endpackage

// File: rtl/issue_ctrl_sb_bits.sv
// Per-register pending-write scoreboard: one set port, one clear port (set wins),
// x0 never pending. CIRNO_ISSUE_BYPASS_EN masks same-cycle clears out of the reads.
module issue_sb_bits
    import issue_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_set_en,
    input  logic [4:0] i_set_idx,
    input  logic       i_clr_en,
    input  logic [4:0] i_clr_idx,
    input  logic [4:0] i_rs1_idx,
    input  logic [4:0] i_rs2_idx,
    input  logic [4:0] i_rd_idx,
    output logic       o_rs1_pend,
    output logic       o_rs2_pend,
    output logic       o_rd_pend
);

    logic [31:0] r_pend;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_pend_nxt;
    logic [31:0] w_pend_rd;

    assign w_set_mask = i_set_en ? (32'd1 << i_set_idx) : 32'd0;
    assign w_clr_mask = i_clr_en ? (32'd1 << i_clr_idx) : 32'd0;

    always_comb begin
        w_pend_nxt    = (r_pend & ~w_clr_mask) | w_set_mask;
        w_pend_nxt[0] = 1'b0;
    end

    // NOTE: the pending vector is control state, not data storage, so it must be reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_pend <= '0;
        else
            r_pend <= w_pend_nxt;
    end

`ifdef CIRNO_ISSUE_BYPASS_EN
    assign w_pend_rd = r_pend & ~w_clr_mask;
`else
    assign w_pend_rd = r_pend;
`endif

    assign o_rs1_pend = w_pend_rd[i_rs1_idx];
    assign o_rs2_pend = w_pend_rd[i_rs2_idx];
    assign o_rd_pend  = w_pend_rd[i_rd_idx];

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: RAW/WAW scoreboard stall, outstanding-op count, CSR and trap
// serialisation behind a pipeline drain. Optional macro: CIRNO_ISSUE_BYPASS_EN.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int OST_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_dec_val,
    output logic               o_dec_rdy,
    input  logic [USELE_W-1:0] i_usele,
    input  logic               i_rs1_ren,
    input  logic               i_rs2_ren,
    input  logic               i_rd_wen,
    input  logic [4:0]         i_rs1_idx,
    input  logic [4:0]         i_rs2_idx,
    input  logic [4:0]         i_rd_idx,
    input  logic               i_ilgl,
    input  logic [1:0]         i_ecallbreak,
    output logic               o_iss_val,
    input  logic               i_iss_rdy,
    output logic [USELE_W-1:0] o_iss_usele,
    input  logic               i_ret_val,
    input  logic               i_ret_rd_wen,
    input  logic [4:0]         i_ret_rd_idx,
    input  logic               i_flush,
    output logic               o_trap_val,
    output logic [1:0]         o_trap_cause,
    input  logic               i_trap_ack,
    output logic               o_busy,
    output logic               o_ost_err
);

    localparam int               OST_W   = $clog2(OST_DEPTH) + 1;
    localparam logic [OST_W-1:0] OST_MAX = OST_W'(OST_DEPTH);
    localparam logic [OST_W-1:0] OST_ONE = OST_W'(1);

    issue_st_e        r_state;
    issue_st_e        w_state_nxt;
    trap_cause_e      r_cause;
    logic [OST_W-1:0] r_ost;
    logic             r_ost_err;

    logic w_rs1_pend, w_rs2_pend, w_rd_pend;
    logic w_hazard, w_trap_req, w_ret_clr, w_ost_zero, w_ost_drained;
    logic w_iss_val, w_dec_rdy, w_trap_val, w_cause_ld, w_iss;

    assign w_ret_clr  = i_ret_val & i_ret_rd_wen & (i_ret_rd_idx != 5'd0);
    assign w_iss      = w_iss_val & i_iss_rdy;
    assign w_trap_req = i_ilgl | (|i_ecallbreak);
    assign w_ost_zero = (r_ost == '0);

    issue_sb_bits u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_en   (w_iss & i_rd_wen),
        .i_set_idx  (i_rd_idx),
        .i_clr_en   (w_ret_clr),
        .i_clr_idx  (i_ret_rd_idx),
        .i_rs1_idx  (i_rs1_idx),
        .i_rs2_idx  (i_rs2_idx),
        .i_rd_idx   (i_rd_idx),
        .o_rs1_pend (w_rs1_pend),
        .o_rs2_pend (w_rs2_pend),
        .o_rd_pend  (w_rd_pend)
    );

    assign w_hazard = (i_rs1_ren & w_rs1_pend) | (i_rs2_ren & w_rs2_pend) | (i_rd_wen & w_rd_pend);

`ifdef CIRNO_ISSUE_BYPASS_EN
    assign w_ost_drained = w_ost_zero | ((r_ost == OST_ONE) & i_ret_val);
`else
    assign w_ost_drained = w_ost_zero;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_iss_val   = 1'b0;
        w_dec_rdy   = 1'b0;
        w_trap_val  = 1'b0;
        w_cause_ld  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_dec_val && !i_flush) begin
                    if (w_trap_req) begin
                        w_state_nxt = ST_TRAP;
                        w_dec_rdy   = 1'b1;
                        w_cause_ld  = 1'b1;
                    end else if (i_usele == '0) begin
                        w_dec_rdy = 1'b1;
                    end else if (i_usele[SELE_CSU] && !w_ost_zero) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_iss_val = !w_hazard && (r_ost < OST_MAX);
                        w_dec_rdy = w_iss_val & i_iss_rdy;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_flush || w_ost_drained)
                    w_state_nxt = ST_RUN;
            end
            ST_TRAP: begin
                if (w_ost_drained) begin
                    w_state_nxt = ST_HALT;
                    w_trap_val  = 1'b1;
                end
            end
            ST_HALT: begin
                if (i_trap_ack)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_RUN;
            r_cause   <= TRAP_NONE;
            r_ost     <= '0;
            r_ost_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cause_ld)
                r_cause <= trap_cause(i_ilgl, i_ecallbreak);
            if (i_ret_val && w_ost_zero)
                r_ost_err <= 1'b1;
            // Simultaneous issue and retire leave the count untouched.
            case ({w_iss, i_ret_val})
                2'b10:   r_ost <= r_ost + OST_ONE;
                2'b01:   if (!w_ost_zero) r_ost <= r_ost - OST_ONE;
                default: r_ost <= r_ost;
            endcase
        end
    end

    assign o_dec_rdy    = w_dec_rdy;
    assign o_iss_val    = w_iss_val;
    assign o_iss_usele  = i_usele & {USELE_W{w_iss_val}};
    assign o_trap_val   = w_trap_val;
    assign o_trap_cause = r_cause;
    assign o_busy       = !w_ost_zero;
    assign o_ost_err    = r_ost_err;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: expected handshake results are queued as each
// step is driven and popped when the DUT outputs are sampled.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam logic [3:0] ALU = 4'b0001;
    localparam logic [3:0] AGU = 4'b0100;
    localparam logic [3:0] CSU = 4'b1000;
    localparam logic [3:0] NOP = 4'b0000;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_dec_val, o_dec_rdy;
    logic [3:0] i_usele, o_iss_usele;
    logic       i_rs1_ren, i_rs2_ren, i_rd_wen;
    logic [4:0] i_rs1_idx, i_rs2_idx, i_rd_idx;
    logic       i_ilgl;
    logic [1:0] i_ecallbreak;
    logic       o_iss_val, i_iss_rdy;
    logic       i_ret_val, i_ret_rd_wen;
    logic [4:0] i_ret_rd_idx;
    logic       i_flush;
    logic       o_trap_val;
    logic [1:0] o_trap_cause;
    logic       i_trap_ack;
    logic       o_busy, o_ost_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       iss;
        logic       rdy;
        logic [3:0] sele;
    } exp_t;

    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    issue_ctrl #(.OST_DEPTH(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_dec_val    (i_dec_val),
        .o_dec_rdy    (o_dec_rdy),
        .i_usele      (i_usele),
        .i_rs1_ren    (i_rs1_ren),
        .i_rs2_ren    (i_rs2_ren),
        .i_rd_wen     (i_rd_wen),
        .i_rs1_idx    (i_rs1_idx),
        .i_rs2_idx    (i_rs2_idx),
        .i_rd_idx     (i_rd_idx),
        .i_ilgl       (i_ilgl),
        .i_ecallbreak (i_ecallbreak),
        .o_iss_val    (o_iss_val),
        .i_iss_rdy    (i_iss_rdy),
        .o_iss_usele  (o_iss_usele),
        .i_ret_val    (i_ret_val),
        .i_ret_rd_wen (i_ret_rd_wen),
        .i_ret_rd_idx (i_ret_rd_idx),
        .i_flush      (i_flush),
        .o_trap_val   (o_trap_val),
        .o_trap_cause (o_trap_cause),
        .i_trap_ack   (i_trap_ack),
        .o_busy       (o_busy),
        .o_ost_err    (o_ost_err)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        i_dec_val    = 1'b0;
        i_usele      = NOP;
        i_rs1_ren    = 1'b0;
        i_rs2_ren    = 1'b0;
        i_rd_wen     = 1'b0;
        i_rs1_idx    = 5'd0;
        i_rs2_idx    = 5'd0;
        i_rd_idx     = 5'd0;
        i_ilgl       = 1'b0;
        i_ecallbreak = 2'b00;
        i_flush      = 1'b0;
        i_iss_rdy    = 1'b1;
        i_trap_ack   = 1'b0;
    endtask

    task automatic op(input logic [3:0] sele, input logic r1en, input logic [4:0] r1,
                      input logic r2en, input logic [4:0] r2, input logic wen, input logic [4:0] rd);
        idle();
        i_dec_val = 1'b1;
        i_usele   = sele;
        i_rs1_ren = r1en;
        i_rs1_idx = r1;
        i_rs2_ren = r2en;
        i_rs2_idx = r2;
        i_rd_wen  = wen;
        i_rd_idx  = rd;
    endtask

    task automatic ret(input logic [4:0] idx, input logic wen);
        i_ret_val    = 1'b1;
        i_ret_rd_wen = wen;
        i_ret_rd_idx = idx;
    endtask

    task automatic noret();
        i_ret_val    = 1'b0;
        i_ret_rd_wen = 1'b0;
        i_ret_rd_idx = 5'd0;
    endtask

    // Queue the expected handshake, sample mid-cycle, compare, then advance one clock.
    task automatic step(input string tag, input logic iss, input logic rdy);
        exp_t e;
        e.tag  = tag;
        e.iss  = iss;
        e.rdy  = rdy;
        e.sele = iss ? i_usele : 4'b0000;
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        check({e.tag, ".iss_val"}, {7'd0, o_iss_val}, {7'd0, e.iss});
        check({e.tag, ".dec_rdy"}, {7'd0, o_dec_rdy}, {7'd0, e.rdy});
        check({e.tag, ".usele"}, {4'd0, o_iss_usele}, {4'd0, e.sele});
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        idle();
        noret();
        i_rst = 1'b1;
        #1;
        check("rst.dec_rdy", {7'd0, o_dec_rdy}, 8'd0);
        check("rst.iss_val", {7'd0, o_iss_val}, 8'd0);
        check("rst.trap_val", {7'd0, o_trap_val}, 8'd0);
        check("rst.trap_cause", {6'd0, o_trap_cause}, 8'd0);
        check("rst.busy", {7'd0, o_busy}, 8'd0);
        check("rst.ost_err", {7'd0, o_ost_err}, 8'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // RAW hazard on x5
        op(ALU, 1, 5'd1, 1, 5'd2, 1, 5'd5);  step("add_x5", 1, 1);
        check("add_x5.busy", {7'd0, o_busy}, 8'd1);
        op(ALU, 1, 5'd5, 1, 5'd1, 1, 5'd6);  step("raw_stall", 0, 0);
        ret(5'd5, 1);
`ifdef CIRNO_ISSUE_BYPASS_EN
        step("raw_bypass", 1, 1);
`else
        step("raw_ret_cycle", 0, 0);
        noret();
        step("raw_next", 1, 1);
`endif
        idle(); ret(5'd6, 1);                step("ret_x6", 0, 0);
        noret();
        check("raw_done.busy", {7'd0, o_busy}, 8'd0);

        // x0 is never pending
        op(ALU, 1, 5'd0, 1, 5'd0, 1, 5'd0);  step("wr_x0", 1, 1);
        op(ALU, 1, 5'd0, 1, 5'd0, 1, 5'd7);  step("rd_x0", 1, 1);
        idle(); ret(5'd0, 1);                step("ret_x0", 0, 0);
        ret(5'd7, 1);                        step("ret_x7", 0, 0);
        noret();
        check("x0_done.busy", {7'd0, o_busy}, 8'd0);

        // nop and flush in RUN
        op(NOP, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("nop", 0, 1);
        op(ALU, 1, 5'd1, 0, 5'd0, 1, 5'd9);
        i_flush = 1'b1;                      step("flush_run", 0, 0);
        check("flush_run.busy", {7'd0, o_busy}, 8'd0);

        // outstanding limit
        for (int i = 0; i < 4; i++) begin
            op(AGU, 0, 5'd0, 0, 5'd0, 1, 5'(10 + i));
            step("ld_fill", 1, 1);
        end
        op(AGU, 0, 5'd0, 0, 5'd0, 1, 5'd14); step("ld5_full", 0, 0);
        ret(5'd10, 1);                       step("ld5_full_ret", 0, 0);
        noret();                             step("ld5_issue", 1, 1);
        op(AGU, 0, 5'd0, 0, 5'd0, 1, 5'd15);
        ret(5'd11, 1);                       step("ld6_full_ret", 0, 0);
        ret(5'd12, 1);                       step("ld6_iss_ret", 1, 1);
        noret();
        op(AGU, 0, 5'd0, 0, 5'd0, 1, 5'd16); step("ld7_fill", 1, 1);
        op(AGU, 0, 5'd0, 0, 5'd0, 1, 5'd17); step("ld8_full", 0, 0);
        idle();
        for (int i = 0; i < 4; i++) begin
            ret(5'(13 + i), 1);
            step("ld_drain", 0, 0);
        end
        noret();
        check("ld_done.busy", {7'd0, o_busy}, 8'd0);

        // CSR waits for drain
        op(ALU, 0, 5'd0, 0, 5'd0, 1, 5'd20); step("pre_csr1", 1, 1);
        op(ALU, 0, 5'd0, 0, 5'd0, 1, 5'd21); step("pre_csr2", 1, 1);
        op(CSU, 1, 5'd1, 0, 5'd0, 1, 5'd22); step("csr_drain", 0, 0);
        step("csr_in_drain", 0, 0);
        ret(5'd20, 1);                       step("drain_ret1", 0, 0);
        ret(5'd21, 1);                       step("drain_ret2", 0, 0);
        noret();
`ifndef CIRNO_ISSUE_BYPASS_EN
        step("drain_exit", 0, 0);
`endif
        step("csr_issue", 1, 1);
        check("csr_issue.busy", {7'd0, o_busy}, 8'd1);
        idle(); ret(5'd22, 1);               step("ret_csr", 0, 0);
        noret();

        // ecall behind one outstanding op
        op(ALU, 0, 5'd0, 0, 5'd0, 1, 5'd23); step("pre_ecall", 1, 1);
        op(NOP, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        i_ecallbreak = 2'b10;                step("ecall", 0, 1);
        idle();
        i_flush = 1'b1;
        #1;
        check("trap_hold.trap_val", {7'd0, o_trap_val}, 8'd0);
        step("trap_hold", 0, 0);
        i_flush = 1'b0;
        ret(5'd23, 1);
`ifndef CIRNO_ISSUE_BYPASS_EN
        #1;
        check("trap_wait.trap_val", {7'd0, o_trap_val}, 8'd0);
        step("trap_wait", 0, 0);
        noret();
`endif
        #1;
        check("ecall.trap_val", {7'd0, o_trap_val}, 8'd1);
        check("ecall.cause", {6'd0, o_trap_cause}, 8'(TRAP_ECALL));
        step("trap_pulse", 0, 0);
        noret();
        #1;
        check("trap_one_cycle", {7'd0, o_trap_val}, 8'd0);
        op(ALU, 1, 5'd1, 0, 5'd0, 1, 5'd9);  step("halt_block", 0, 0);
        i_trap_ack = 1'b1;                   step("halt_ack", 0, 0);
        i_trap_ack = 1'b0;                   step("run_after_ack", 1, 1);
        idle(); ret(5'd9, 1);                step("ret_x9", 0, 0);
        noret();

        // illegal outranks ebreak; no outstanding ops so the pulse is immediate
        op(ALU, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        i_ilgl = 1'b1; i_ecallbreak = 2'b01; step("ilgl", 0, 1);
        idle();
        #1;
        check("ilgl.trap_val", {7'd0, o_trap_val}, 8'd1);
        check("ilgl.cause", {6'd0, o_trap_cause}, 8'(TRAP_ILGL));
        step("ilgl_pulse", 0, 0);
        i_trap_ack = 1'b1;                   step("ilgl_ack", 0, 0);
        i_trap_ack = 1'b0;

        // flush in DRAIN returns to RUN and keeps pend/ost
        op(ALU, 0, 5'd0, 0, 5'd0, 1, 5'd24); step("pre_drain", 1, 1);
        op(CSU, 0, 5'd0, 0, 5'd0, 1, 5'd26); step("csr_drain2", 0, 0);
        i_flush = 1'b1;                      step("drain_flush", 0, 0);
        i_flush = 1'b0;
        check("drain_flush.busy", {7'd0, o_busy}, 8'd1);
        op(ALU, 1, 5'd24, 0, 5'd0, 1, 5'd27); step("pend_kept", 0, 0);
        idle(); ret(5'd24, 1);               step("ret_x24", 0, 0);
        check("pre_err.ost_err", {7'd0, o_ost_err}, 8'd0);
        ret(5'd0, 0);                        step("ret_empty", 0, 0);
        noret();
        check("ost_err.set", {7'd0, o_ost_err}, 8'd1);
        check("ost_err.busy", {7'd0, o_busy}, 8'd0);
        step("idle1", 0, 0);
        step("idle2", 0, 0);
        check("ost_err.sticky", {7'd0, o_ost_err}, 8'd1);

        // reset while a trap waits on an outstanding op
        op(ALU, 0, 5'd0, 0, 5'd0, 1, 5'd25); step("pre_rst", 1, 1);
        op(NOP, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        i_ecallbreak = 2'b01;                step("ebreak_rst", 0, 1);
        idle();
        i_rst = 1'b1;
        #1;
        check("mid_rst.busy", {7'd0, o_busy}, 8'd0);
        check("mid_rst.trap_val", {7'd0, o_trap_val}, 8'd0);
        check("mid_rst.cause", {6'd0, o_trap_cause}, 8'd0);
        check("mid_rst.ost_err", {7'd0, o_ost_err}, 8'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        op(ALU, 1, 5'd25, 0, 5'd0, 1, 5'd28); step("after_rst", 1, 1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
